// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the instruction memory each cycle
// and queues {pc, instr} in a 2-entry prefetch buffer for decode.
module instr_fetch_unit #(
    parameter int          BITS     = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_endr,
    input  logic [BITS-1:0]   imem_dout,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS-1:0]   out_instr,
    output logic [31:0]       out_pc
);

    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    logic [31:0]     pc;
    logic [31:0]     pc_next;
    logic [1:0]      count;
    logic [1:0]      count_next;
    logic [BITS-1:0] head_instr;
    logic [BITS-1:0] head_instr_next;
    logic [31:0]     head_pc;
    logic [31:0]     head_pc_next;
    logic [BITS-1:0] tail_instr;
    logic [BITS-1:0] tail_instr_next;
    logic [31:0]     tail_pc;
    logic [31:0]     tail_pc_next;
    logic            pop;
    logic            push;

    // Memory address comes straight from the register: no handshake path.
    assign imem_endr = pc[ADDR_W+1:2];

    assign out_valid = (count != 2'd0);
    assign out_instr = head_instr;
    assign out_pc    = head_pc;

    assign pop  = out_valid & out_ready;
    assign push = !redirect_valid & ((count != 2'd2) | pop);

    always_comb begin
        pc_next         = pc;
        count_next      = count;
        head_instr_next = head_instr;
        head_pc_next    = head_pc;
        tail_instr_next = tail_instr;
        tail_pc_next    = tail_pc;
        if (redirect_valid) begin
            // Flush; head registers keep their last contents.
            count_next = 2'd0;
            pc_next    = redirect_pc & PC_MASK;
        end else begin
            if (push) begin
                pc_next = pc + 32'd4;
            end
            unique case (count)
                2'd0: begin
                    if (push) begin
                        head_instr_next = imem_dout;
                        head_pc_next    = pc;
                        count_next      = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_instr_next = imem_dout;
                        head_pc_next    = pc;
                    end else if (push) begin
                        tail_instr_next = imem_dout;
                        tail_pc_next    = pc;
                        count_next      = 2'd2;
                    end else if (pop) begin
                        count_next = 2'd0;
                    end
                end
                2'd2: begin
                    // At count 2 a pop always comes with a push.
                    if (pop) begin
                        head_instr_next = tail_instr;
                        head_pc_next    = tail_pc;
                        tail_instr_next = imem_dout;
                        tail_pc_next    = pc;
                    end
                end
                default: begin
                    count_next = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC & PC_MASK;
            count      <= 2'd0;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else begin
            pc         <= pc_next;
            count      <= count_next;
            head_instr <= head_instr_next;
            head_pc    <= head_pc_next;
            tail_instr <= tail_instr_next;
            tail_pc    <= tail_pc_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic,
// checked against a queue-based model of the prefetch buffer.
module tb_instr_fetch_unit;

    localparam int          BITS     = 32;
    localparam int          ADDR_W   = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_endr;
    logic [BITS-1:0]   imem_dout;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [BITS-1:0]   out_instr;
    logic [31:0]       out_pc;

    logic [BITS-1:0] mem [2**ADDR_W];

    int checks;
    int errors;

    // Model state: queue of {pc, instr}, fetch pc, last head shown.
    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic [63:0] m_last;

    instr_fetch_unit #(
        .BITS(BITS),
        .ADDR_W(ADDR_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_endr(imem_endr),
        .imem_dout(imem_dout),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    assign imem_dout = mem[imem_endr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS-1:0] word_at(input logic [31:0] a);
        return mem[(a / 4) % (2**ADDR_W)];
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_last = '0;
    endtask

    task automatic model_step(input bit rdy, input bit rv,
                              input logic [31:0] rpc);
        bit popped;
        bit pushed;
        popped = (q.size() != 0) && rdy;
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            pushed = (q.size() < 2) || popped;
            if (popped) void'(q.pop_front());
            if (pushed) begin
                q.push_back({m_pc, word_at(m_pc)});
                m_pc = m_pc + 4;
            end
        end
        if (q.size() != 0) m_last = q[0];
    endtask

    task automatic check_model();
        logic [63:0] h;
        h = (q.size() != 0) ? q[0] : m_last;
        check("valid", 64'(out_valid), 64'(q.size() != 0));
        check("pc", 64'(out_pc), 64'(h[63:32]));
        check("instr", 64'(out_instr), 64'(h[31:0]));
        check("endr", 64'(imem_endr), 64'((m_pc / 4) % (2**ADDR_W)));
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input bit rdy, input bit rv,
                         input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_step(rdy, rv, rpc);
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_1217;
        mem[1] = 32'h0406_0267;
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        model_reset();

        // Reset values
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_endr", 64'(imem_endr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Startup stream
        cycle(1, 0, 0);
        check("st1_valid", 64'(out_valid), 64'd1);
        check("st1_pc", 64'(out_pc), 64'h0);
        check("st1_instr", 64'(out_instr), 64'h0000_1217);
        cycle(1, 0, 0);
        check("st2_pc", 64'(out_pc), 64'h4);
        check("st2_instr", 64'(out_instr), 64'h0406_0267);

        // Backpressure
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        check("bp_endr", 64'(imem_endr), 64'd2);
        check("bp_pc", 64'(out_pc), 64'h0);
        check("bp_valid", 64'(out_valid), 64'd1);
        cycle(1, 0, 0);
        check("bp_pc4", 64'(out_pc), 64'h4);
        cycle(1, 0, 0);
        check("bp_pc8", 64'(out_pc), 64'h8);

        // Redirect while full and stalled
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h40);
        check("rd_bubble", 64'(out_valid), 64'd0);
        cycle(0, 0, 0);
        check("rd_pc", 64'(out_pc), 64'h40);
        check("rd_instr", 64'(out_instr), 64'(mem[16]));
        cycle(0, 0, 0);
        check("rd_hold", 64'(out_pc), 64'h40);

        // Misaligned target and memory wrap
        cycle(0, 1, 32'h7E);
        check("mw_endr31", 64'(imem_endr), 64'd31);
        cycle(1, 0, 0);
        check("mw_pc7c", 64'(out_pc), 64'h7C);
        check("mw_endr0", 64'(imem_endr), 64'd0);
        cycle(1, 0, 0);
        check("mw_pc80", 64'(out_pc), 64'h80);
        check("mw_instr", 64'(out_instr), 64'h0000_1217);

        // Pop and redirect together
        cycle(1, 1, 32'h20);
        check("pr_flush", 64'(out_valid), 64'd0);
        cycle(1, 0, 0);
        check("pr_pc", 64'(out_pc), 64'h20);

        // Asynchronous reset between edges while full
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("ar_full", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_pc", 64'(out_pc), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0);
        check("ar_restart", 64'(out_pc), 64'(RESET_PC));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 9) == 0);
            cycle(r, v, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
